muldiv_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide sequencer with architectural HI/LO registers for the 5-stage MIPS pipeline. Sits in EX beside the ALU.
- Consumes the start, op, HI/LO write and HI/LO select controls produced by the EX decoder.
- Generalises the fixed 32-bit unit with configurable data width, separate multiply and divide latencies, and defined divide-by-zero/overflow results.
- Drives a stall request back to the hazard unit.

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Multiply/divide sequencer control and result bundle.
// The EX stage decoder drives the master side; muldiv_seq takes the slave side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             hilo_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, hilo_we, hilo_sel, wdata, hilo_rd,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_sel, wdata, hilo_rd,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Latency is modelled by a down-counter; the result is computed from the
// operands latched at start and committed to HI/LO on the FINISH edge.
module muldiv_seq #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, load_cnt;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [1:0]         op_q;
  logic               done_q;
  logic               busy;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign busy      = (state_q != S_IDLE);
  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.start | bus.hilo_rd | bus.hilo_we);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Latency count to load on an accepted start, chosen by mul/div class.
  always_comb begin
    load_cnt = bus.op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  end

  // Next-state and counter logic; a zero load count skips RUN entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // Result from latched operands; divide-by-zero and signed overflow are
  // resolved explicitly so the divider never sees those cases.
  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    if (!op_q[1]) begin
      if (op_q[0])
        prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      else
        prod = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
               $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
      {res_hi, res_lo} = prod;
    end else if (b_q == '0) begin
      res_lo = '1;
      res_hi = a_q;
    end else if (!op_q[0] && a_q == MOST_NEG && b_q == '1) begin
      res_lo = a_q;
      res_hi = '0;
    end else if (op_q[0]) begin
      res_lo = a_q / b_q;
      res_hi = a_q % b_q;
    end else begin
      res_lo = $unsigned($signed(a_q) / $signed(b_q));
      res_hi = $unsigned($signed(a_q) % $signed(b_q));
    end
  end

  // HI/LO update: operation result on FINISH, mthi/mtlo only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_FINISH) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == S_IDLE && bus.hilo_we) begin
      if (bus.hilo_sel) hi_q <= bus.wdata;
      else              lo_q <= bus.wdata;
    end
  end

  // Completion pulse for the cycle after the HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_q == S_FINISH);
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a 32-bit default instance and a 16-bit
// instance with MUL_LAT=1, DIV_LAT=3. Expected results come from a plain
// integer reference model; a negedge monitor pops them on done.
module tb_muldiv_seq;

  typedef struct {
    longint unsigned hi;
    longint unsigned lo;
    longint          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) if32 ();
  muldiv_seq_if #(.WIDTH(16)) if16 ();

  muldiv_seq #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32)
  );
  muldiv_seq #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );

  exp_t            q0[$];
  exp_t            q1[$];
  longint          cyc = 0;
  longint          free_e[2];
  longint unsigned mhi[2];
  longint unsigned mlo[2];
  int              checks = 0;
  int              failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(int s);
    return (s != 0) ? 16 : 32;
  endfunction

  function automatic int lat(int s, logic [1:0] op);
    if (s != 0) return op[1] ? 3 : 1;
    return op[1] ? 10 : 5;
  endfunction

  function automatic longint unsigned msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(longint unsigned v, int w);
    longint unsigned m;
    m = 64'd1 << (w - 1);
    return longint'((v ^ m) - m);
  endfunction

  // Reference: MIPS mult/multu/div/divu semantics in 64-bit integers.
  function automatic exp_t model(int w, logic [1:0] op, longint unsigned a, longint unsigned b);
    exp_t e;
    longint unsigned m, up;
    longint sa, sb, p, mn;
    m  = msk(w);
    sa = sx(a, w);
    sb = sx(b, w);
    mn = -(64'sd1 <<< (w - 1));
    e.due = 0;
    case (op)
      2'b00: begin
        p = sa * sb;
        e.lo = $unsigned(p) & m;
        e.hi = ($unsigned(p) >> w) & m;
      end
      2'b01: begin
        up = a * b;
        e.lo = up & m;
        e.hi = (up >> w) & m;
      end
      default: begin
        if (b == 0) begin
          e.lo = m;
          e.hi = a;
        end else if (op == 2'b10 && sa == mn && sb == -1) begin
          e.lo = a;
          e.hi = 0;
        end else if (op == 2'b10) begin
          e.lo = $unsigned(sa / sb) & m;
          e.hi = $unsigned(sa % sb) & m;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  function automatic longint unsigned rnd(int w);
    case ($urandom_range(0, 7))
      0: return 0;
      1: return msk(w);
      2: return 64'd1 << (w - 1);
      3: return 1;
      default: return {32'd0, $urandom} & msk(w);
    endcase
  endfunction

  function automatic longint unsigned o_hi(int s);
    if (s != 0) return 64'(if16.hi);
    return 64'(if32.hi);
  endfunction
  function automatic longint unsigned o_lo(int s);
    if (s != 0) return 64'(if16.lo);
    return 64'(if32.lo);
  endfunction
  function automatic longint unsigned o_busy(int s);
    return (s != 0) ? 64'(if16.busy) : 64'(if32.busy);
  endfunction
  function automatic longint unsigned o_stall(int s);
    return (s != 0) ? 64'(if16.stall) : 64'(if32.stall);
  endfunction
  function automatic longint unsigned o_done(int s);
    return (s != 0) ? 64'(if16.done) : 64'(if32.done);
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_op(int s, bit st, logic [1:0] op, longint unsigned a, longint unsigned b);
    if (s == 0) begin
      if32.start = st; if32.op = op; if32.a = a[31:0]; if32.b = b[31:0];
    end else begin
      if16.start = st; if16.op = op; if16.a = a[15:0]; if16.b = b[15:0];
    end
  endtask

  task automatic set_we(int s, bit we, bit hs, longint unsigned wd);
    if (s == 0) begin
      if32.hilo_we = we; if32.hilo_sel = hs; if32.wdata = wd[31:0];
    end else begin
      if16.hilo_we = we; if16.hilo_sel = hs; if16.wdata = wd[15:0];
    end
  endtask

  task automatic set_rd(int s, bit rd);
    if (s == 0) if32.hilo_rd = rd;
    else        if16.hilo_rd = rd;
  endtask

  // Present a start and hold it until the model says the unit is idle.
  task automatic issue(int s, logic [1:0] op, longint unsigned a_in, longint unsigned b_in);
    exp_t            e;
    longint          acc;
    longint unsigned a, b;
    int              w, l;
    w = wid(s);
    a = a_in & msk(w);
    b = b_in & msk(w);
    l = lat(s, op);
    set_op(s, 1'b1, op, a, b);
    #1;
    acc = (cyc + 1 > free_e[s]) ? cyc + 1 : free_e[s];
    while (cyc + 1 < acc) begin
      chk("stall_start_held", o_stall(s), 1);
      @(negedge clk); #1;
    end
    chk("stall_start_idle", o_stall(s), 0);
    e = model(w, op, a, b);
    e.due = acc + l;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    free_e[s] = acc + l + 1;
    mhi[s] = e.hi;
    mlo[s] = e.lo;
    @(negedge clk);
    set_op(s, 1'b0, op, a, b);
  endtask

  // Run out the current operation, optionally with mfhi/mflo waiting.
  task automatic wait_idle(int s, bit rd);
    set_rd(s, rd);
    #1;
    while (cyc + 1 < free_e[s]) begin
      chk("busy_in_flight", o_busy(s), 1);
      chk("stall_rd", o_stall(s), 64'(rd));
      @(negedge clk); #1;
    end
    chk("busy_idle", o_busy(s), 0);
    chk("stall_idle", o_stall(s), 0);
    set_rd(s, 1'b0);
  endtask

  // mthi/mtlo, held while busy, applied on the first idle edge.
  task automatic mt(int s, bit hs, longint unsigned d_in);
    longint          acc;
    longint unsigned d;
    d = d_in & msk(wid(s));
    set_we(s, 1'b1, hs, d);
    #1;
    acc = (cyc + 1 > free_e[s]) ? cyc + 1 : free_e[s];
    while (cyc + 1 < acc) begin
      chk("stall_we_held", o_stall(s), 1);
      @(negedge clk); #1;
    end
    chk("stall_we_idle", o_stall(s), 0);
    chk("hi_before_write", o_hi(s), mhi[s]);
    chk("lo_before_write", o_lo(s), mlo[s]);
    @(negedge clk);
    set_we(s, 1'b0, 1'b0, 0);
    if (hs) mhi[s] = d;
    else    mlo[s] = d;
    #1;
    chk("hi_after_write", o_hi(s), mhi[s]);
    chk("lo_after_write", o_lo(s), mlo[s]);
  endtask

  task automatic check_hilo(int s, longint unsigned ehi, longint unsigned elo);
    chk("hi_value", o_hi(s), ehi);
    chk("lo_value", o_lo(s), elo);
  endtask

  task automatic mon(int s);
    exp_t e;
    bit   have;
    have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (s == 0) ? q0[0] : q1[0];
    if (o_done(s) != 0) begin
      if (!have) begin
        chk("done_spurious", 1, 0);
      end else begin
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("result_hi", o_hi(s), e.hi);
        chk("result_lo", o_lo(s), e.lo);
        if (s == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end else if (have && e.due <= cyc) begin
      chk("done_missing", 0, 1);
      if (s == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      set_op(s, 1'b0, 2'b00, 0, 0);
      set_we(s, 1'b0, 1'b0, 0);
      set_rd(s, 1'b0);
      free_e[s] = 0;
      mhi[s] = 0;
      mlo[s] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_hilo(s, 0, 0);
      chk("reset_busy", o_busy(s), 0);
      chk("reset_done", o_done(s), 0);
      chk("reset_stall", o_stall(s), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    mt(0, 1'b1, 64'hAAAA);
    check_hilo(0, 64'hAAAA, 0);
    mt(0, 1'b0, 64'h5555);

    // Abort an in-flight multiply with reset.
    issue(0, 2'b00, 64'hFFFF_FFFE, 3);
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    free_e[0] = 0;
    mhi[0] = 0;
    mlo[0] = 0;
    #1;
    check_hilo(0, 0, 0);
    chk("abort_busy", o_busy(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check_hilo(0, 0, 0);

    issue(0, 2'b00, 64'hFFFF_FFFE, 3);
    wait_idle(0, 1'b1);
    check_hilo(0, 64'hFFFF_FFFF, 64'hFFFF_FFFA);
    issue(0, 2'b11, 7, 2);
    wait_idle(0, 1'b0);
    check_hilo(0, 1, 3);
    issue(0, 2'b10, 64'hFFFF_FFF9, 2);
    wait_idle(0, 1'b1);
    check_hilo(0, 64'hFFFF_FFFF, 64'hFFFF_FFFD);
    issue(0, 2'b11, 64'h1234, 0);
    wait_idle(0, 1'b0);
    check_hilo(0, 64'h1234, 64'hFFFF_FFFF);
    issue(0, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF);
    wait_idle(0, 1'b0);
    check_hilo(0, 0, 64'h8000_0000);

    // mthi issued while a multiply is running.
    issue(0, 2'b01, 64'h10, 64'h20);
    mt(0, 1'b1, 64'hBEEF);
    check_hilo(0, 64'hBEEF, 64'h200);

    // Back-to-back random operations; each start is held by stall.
    repeat (40) issue(0, 2'($urandom_range(0, 3)), rnd(32), rnd(32));
    wait_idle(0, 1'b0);

    issue(1, 2'b00, 64'h8000, 2);
    wait_idle(1, 1'b0);
    check_hilo(1, 64'hFFFF, 0);
    issue(1, 2'b11, 100, 7);
    issue(1, 2'b10, 64'hFFF9, 2);
    wait_idle(1, 1'b0);
    check_hilo(1, 64'hFFFF, 64'hFFFD);
    repeat (40) issue(1, 2'($urandom_range(0, 3)), rnd(16), rnd(16));
    wait_idle(1, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
